// File: rtl/othello_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : othello_ctrl
// Description : Sequencing controller for the Othello cursor/plot datapath.
//               Turns debounced button levels into one-hot datapath commands,
//               handshakes each sprite redraw with the VGA sprite drawer,
//               enforces board bounds and move legality, and guards every
//               redraw with a shared timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
module othello_ctrl #(
  parameter int PLOT_TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_place,
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic       place_ok,
  input  logic       plot_done,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       plot_empty,
  output logic       plot_box,
  output logic       place_disk,
  output logic       turn_side,
  output logic       plot_start,
  output logic       busy,
  output logic       reject,
  output logic       timeout_err
);

  localparam int              c_CW      = $clog2(PLOT_TIMEOUT);
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(PLOT_TIMEOUT - 1);

  // Key vector bit positions, highest index = highest priority.
  localparam int c_K_RIGHT = 0;
  localparam int c_K_LEFT  = 1;
  localparam int c_K_DOWN  = 2;
  localparam int c_K_UP    = 3;
  localparam int c_K_PLACE = 4;

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_IDLE  = 4'd1,
    S_MOVE  = 4'd2,
    S_MGAP  = 4'd3,
    S_ERASE = 4'd4,
    S_DRAW  = 4'd5,
    S_PLACE = 4'd6,
    S_TURN  = 4'd7,
    S_TGAP  = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    D_UP    = 2'd0,
    D_DOWN  = 2'd1,
    D_LEFT  = 2'd2,
    D_RIGHT = 2'd3
  } dir_t;

  state_t          r_state;
  state_t          w_state_nxt;
  dir_t            r_dir;
  dir_t            w_dir_nxt;
  dir_t            w_mv_dir;
  logic            w_mv_ev;
  logic            w_mv_edge;
  logic [4:0]      w_key;
  logic [4:0]      r_prev;
  logic [4:0]      w_ev;
  logic [c_CW-1:0] r_cnt;
  logic            w_expired;
  logic            w_wait;
  logic            r_run;
  logic            r_timeout_err;
  logic            w_timeout_set;
  logic            r_reject;
  logic            w_reject_set;

  assign w_key     = {key_place, key_up, key_down, key_left, key_right};
  assign w_ev      = w_key & ~r_prev;
  assign w_expired = (r_cnt == c_CNT_MAX);
  assign w_wait    = (r_state == S_INIT) || (r_state == S_ERASE) ||
                     (r_state == S_DRAW) || (r_state == S_PLACE);

  // Previous key levels, refreshed every cycle so a held key never re-fires.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) r_prev <= '0;
    else        r_prev <= w_key;
  end

  // r_run masks the outputs while reset is applied and arms INIT on the
  // first clock after release, so the INIT redraw starts on that edge.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // State, latched direction and the single-cycle reject pulse.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_state  <= S_INIT;
      r_dir    <= D_UP;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir    <= w_dir_nxt;
      r_reject <= w_reject_set;
    end
  end

  // Redraw timeout counter: zeroed on every state change, saturates at max.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_cnt <= '0;
    end else if (!r_run || (w_state_nxt != r_state)) begin
      r_cnt <= '0;
    end else if (!w_expired) begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

  // Sticky drawer-timeout flag; only reset clears it.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)             r_timeout_err <= 1'b0;
    else if (w_timeout_set) r_timeout_err <= 1'b1;
  end

  // Highest-priority move event and whether the cursor is already at that edge.
  always_comb begin
    w_mv_ev   = 1'b1;
    w_mv_dir  = D_UP;
    w_mv_edge = 1'b0;
    if (w_ev[c_K_UP]) begin
      w_mv_dir  = D_UP;
      w_mv_edge = (y == 3'd0);
    end else if (w_ev[c_K_DOWN]) begin
      w_mv_dir  = D_DOWN;
      w_mv_edge = (y == 3'd7);
    end else if (w_ev[c_K_LEFT]) begin
      w_mv_dir  = D_LEFT;
      w_mv_edge = (x == 3'd0);
    end else if (w_ev[c_K_RIGHT]) begin
      w_mv_dir  = D_RIGHT;
      w_mv_edge = (x == 3'd7);
    end else begin
      w_mv_ev   = 1'b0;
    end
  end

  // Next-state logic; plot_done wins over an expiring counter in the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_reject_set  = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      S_INIT: begin
        if (r_run) begin
          if (plot_done) begin
            w_state_nxt = S_IDLE;
          end else if (w_expired) begin
            w_state_nxt   = S_IDLE;
            w_timeout_set = 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (w_ev[c_K_PLACE]) begin
          if (place_ok) w_state_nxt  = S_PLACE;
          else          w_reject_set = 1'b1;
        end else if (w_mv_ev && !w_mv_edge) begin
          w_state_nxt = S_MOVE;
          w_dir_nxt   = w_mv_dir;
        end
      end
      S_MOVE:  w_state_nxt = S_MGAP;
      S_MGAP:  w_state_nxt = S_ERASE;
      S_ERASE: begin
        if (plot_done) begin
          w_state_nxt = S_DRAW;
        end else if (w_expired) begin
          w_state_nxt   = S_IDLE;
          w_timeout_set = 1'b1;
        end
      end
      S_DRAW: begin
        if (plot_done) begin
          w_state_nxt = S_IDLE;
        end else if (w_expired) begin
          w_state_nxt   = S_IDLE;
          w_timeout_set = 1'b1;
        end
      end
      S_PLACE: begin
        if (plot_done) begin
          w_state_nxt = S_TURN;
        end else if (w_expired) begin
          w_state_nxt   = S_IDLE;
          w_timeout_set = 1'b1;
        end
      end
      S_TURN:  w_state_nxt = S_TGAP;
      S_TGAP:  w_state_nxt = S_DRAW;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode, forced low while reset is applied.
  always_comb begin
    move_up    = 1'b0;
    move_down  = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    plot_empty = 1'b0;
    plot_box   = 1'b0;
    place_disk = 1'b0;
    turn_side  = 1'b0;
    plot_start = 1'b0;
    busy       = 1'b0;
    if (r_run) begin
      busy       = (r_state != S_IDLE);
      plot_start = w_wait && (r_cnt == '0);
      case (r_state)
        S_INIT:  plot_box   = 1'b1;
        S_DRAW:  plot_box   = 1'b1;
        S_ERASE: plot_empty = 1'b1;
        S_PLACE: place_disk = 1'b1;
        S_TURN:  turn_side  = 1'b1;
        S_MOVE: begin
          move_up    = (r_dir == D_UP);
          move_down  = (r_dir == D_DOWN);
          move_left  = (r_dir == D_LEFT);
          move_right = (r_dir == D_RIGHT);
        end
        default: ;
      endcase
    end
  end

  assign reject      = r_reject;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_othello_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_othello_ctrl
// Description : Self-checking bench for othello_ctrl (PLOT_TIMEOUT = 8).
//               Cycle-by-cycle vector table plus hand-written reset and
//               timeout-boundary sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_othello_ctrl;

  localparam int c_TO = 8;

  // Expected-output bit masks, ordered as w_out below.
  localparam logic [11:0] MU = 12'h800, MD = 12'h400, ML = 12'h200, MR = 12'h100;
  localparam logic [11:0] PE = 12'h080, PB = 12'h040, PD = 12'h020, TS = 12'h010;
  localparam logic [11:0] PS = 12'h008, BZ = 12'h004, RJ = 12'h002, TE = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  // Key masks: {place, up, down, left, right}.
  localparam logic [4:0] K0 = 5'b00000, KP = 5'b10000, KU = 5'b01000;
  localparam logic [4:0] KD = 5'b00100, KL = 5'b00010, KR = 5'b00001;

  logic clock, resetn;
  logic key_up, key_down, key_left, key_right, key_place;
  logic [2:0] x, y;
  logic place_ok, plot_done;
  logic move_up, move_down, move_left, move_right;
  logic plot_empty, plot_box, place_disk, turn_side;
  logic plot_start, busy, reject, timeout_err;
  logic [11:0] w_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  keys;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        ok;
    logic        done;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[64];
  int   n_vec = 0;

  othello_ctrl #(.PLOT_TIMEOUT(c_TO)) dut (
    .clock(clock), .resetn(resetn),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_place(key_place),
    .x(x), .y(y), .place_ok(place_ok), .plot_done(plot_done),
    .move_up(move_up), .move_down(move_down), .move_left(move_left),
    .move_right(move_right), .plot_empty(plot_empty), .plot_box(plot_box),
    .place_disk(place_disk), .turn_side(turn_side), .plot_start(plot_start),
    .busy(busy), .reject(reject), .timeout_err(timeout_err)
  );

  assign w_out = {move_up, move_down, move_left, move_right, plot_empty, plot_box,
                  place_disk, turn_side, plot_start, busy, reject, timeout_err};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [11:0] exp);
    n_cmp++;
    if (w_out !== exp) begin
      n_err++;
      $display("FAIL %s: outputs got %03h required %03h", nm, w_out, exp);
    end
  endtask

  task automatic add(input logic [4:0] k, input logic [2:0] xi, input logic [2:0] yi,
                     input logic ok, input logic dn, input logic [11:0] exp);
    tbl[n_vec].keys = k;
    tbl[n_vec].x    = xi;
    tbl[n_vec].y    = yi;
    tbl[n_vec].ok   = ok;
    tbl[n_vec].done = dn;
    tbl[n_vec].exp  = exp;
    n_vec++;
  endtask

  // Drive one cycle of inputs (from a negedge), clock once, check at the next negedge.
  task automatic step(input logic [4:0] k, input logic [2:0] xi, input logic [2:0] yi,
                      input logic ok, input logic dn, input logic [11:0] exp, input string nm);
    {key_place, key_up, key_down, key_left, key_right} = k;
    x = xi; y = yi; place_ok = ok; plot_done = dn;
    @(posedge clock);
    @(negedge clock);
    check(nm, exp);
  endtask

  initial begin
    // INIT redraw, done in the 5th plot_box cycle
    add(K0, 0, 0, 0, 0, PB | PS | BZ);
    for (int i = 0; i < 4; i++) add(K0, 0, 0, 0, 0, PB | BZ);
    add(K0, 0, 0, 0, 1, NONE);
    // legal right move from (0,0): MOVE, MGAP, ERASE, DRAW
    add(KR, 0, 0, 0, 0, MR | BZ);
    add(K0, 1, 0, 0, 0, BZ);
    add(K0, 1, 0, 0, 0, PE | PS | BZ);
    add(K0, 1, 0, 0, 0, PE | BZ);
    add(K0, 1, 0, 0, 1, PB | PS | BZ);
    add(K0, 1, 0, 0, 0, PB | BZ);
    add(K0, 1, 0, 0, 1, NONE);
    // edge moves are ignored
    add(KU, 1, 0, 0, 0, NONE);
    add(K0, 1, 0, 0, 0, NONE);
    add(KR, 7, 0, 0, 0, NONE);
    add(KL, 0, 5, 0, 0, NONE);
    add(K0, 0, 5, 0, 0, NONE);
    // illegal place
    add(KP, 0, 5, 0, 0, RJ);
    add(K0, 0, 5, 0, 0, NONE);
    // legal place: PLACE, TURN, TGAP, DRAW
    add(KP, 0, 5, 1, 0, PD | PS | BZ);
    add(K0, 0, 5, 1, 0, PD | BZ);
    add(K0, 0, 5, 1, 1, TS | BZ);
    add(K0, 0, 5, 1, 0, BZ);
    add(K0, 0, 5, 1, 0, PB | PS | BZ);
    add(K0, 0, 5, 1, 1, NONE);
    // place beats a coincident legal up; down pressed while busy never fires
    add(KP | KU, 2, 3, 1, 0, PD | PS | BZ);
    add(KD, 2, 3, 1, 0, PD | BZ);
    add(KD, 2, 3, 1, 1, TS | BZ);
    add(KD, 2, 3, 1, 0, BZ);
    add(KD, 2, 3, 1, 0, PB | PS | BZ);
    add(KD, 2, 3, 1, 1, NONE);
    add(KD, 2, 3, 1, 0, NONE);
    add(K0, 2, 3, 1, 0, NONE);
    // legal down, drawer never answers the erase: 8 ERASE cycles then timeout
    add(KD, 2, 3, 0, 0, MD | BZ);
    add(K0, 2, 4, 0, 0, BZ);
    add(K0, 2, 4, 0, 0, PE | PS | BZ);
    for (int i = 0; i < 7; i++) add(K0, 2, 4, 0, 0, PE | BZ);
    add(K0, 2, 4, 0, 0, TE);
    add(K0, 2, 4, 0, 0, TE);
    add(K0, 2, 4, 0, 1, TE);

    // reset phase: outputs stay low regardless of inputs
    resetn = 1'b1;
    {key_place, key_up, key_down, key_left, key_right} = K0;
    x = 0; y = 0; place_ok = 0; plot_done = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_state", NONE);
    {key_place, key_right} = 2'b11; plot_done = 1;
    @(posedge clock);
    @(negedge clock);
    check("reset_inputs_ignored", NONE);
    resetn = 1'b0;

    for (int i = 0; i < n_vec; i++)
      step(tbl[i].keys, tbl[i].x, tbl[i].y, tbl[i].ok, tbl[i].done, tbl[i].exp,
           $sformatf("vec%0d", i));

    // asynchronous reset in the middle of a place redraw
    step(KP, 3, 3, 1, 0, PD | PS | BZ | TE, "place_before_reset");
    step(K0, 3, 3, 1, 0, PD | BZ | TE, "place_hold_before_reset");
    #1 resetn = 1'b1;
    #1 check("reset_async_clear", NONE);
    @(posedge clock);
    @(negedge clock);
    check("reset_held", NONE);
    resetn = 1'b0;
    step(K0, 0, 0, 0, 0, PB | PS | BZ, "init_after_reset");
    step(K0, 0, 0, 0, 0, PB | BZ, "init_wait");
    step(K0, 0, 0, 0, 1, NONE, "init_done_idle");

    // plot_done on the final allowed ERASE cycle wins over the timeout
    step(KR, 0, 0, 0, 0, MR | BZ, "move_right2");
    step(K0, 1, 0, 0, 0, BZ, "mgap2");
    step(K0, 1, 0, 0, 0, PE | PS | BZ, "erase2_c0");
    for (int i = 1; i < c_TO; i++)
      step(K0, 1, 0, 0, 0, PE | BZ, $sformatf("erase2_c%0d", i));
    step(K0, 1, 0, 0, 1, PB | PS | BZ, "done_on_last_cycle");
    step(K0, 1, 0, 0, 0, PB | BZ, "draw2_wait");
    step(K0, 1, 0, 0, 1, NONE, "draw2_done");

    // drawer never answers the final DRAW: timeout out of DRAW as well
    step(KL, 1, 0, 0, 0, ML | BZ, "move_left3");
    step(K0, 0, 0, 0, 0, BZ, "mgap3");
    step(K0, 0, 0, 0, 0, PE | PS | BZ, "erase3_c0");
    step(K0, 0, 0, 0, 1, PB | PS | BZ, "erase3_done");
    for (int i = 1; i < c_TO; i++)
      step(K0, 0, 0, 0, 0, PB | BZ, $sformatf("draw3_c%0d", i));
    step(K0, 0, 0, 0, 0, TE, "draw3_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
